// File: rtl/msg_request_scheduler.sv
// msg_request_scheduler: queues session-layer create requests in arrival order and
// hands them to the message creator one at a time. The creator sees the fields of the
// issued request held stable until it reports completion or times out.
module msg_request_scheduler #(
  parameter int NUM_HOST     = 10,
  parameter int VALUE_WIDTH  = 256,
  parameter int DEPTH        = 8,
  parameter int DONE_TIMEOUT = 1024
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid_i,
  input  logic [3:0]                   req_type_i,
  input  logic [NUM_HOST-1:0]          req_host_i,
  input  logic [VALUE_WIDTH-1:0]       req_compid_i,
  input  logic                         creator_busy_i,
  input  logic                         creator_done_i,
  output logic [3:0]                   create_message_o,
  output logic                         initiate_msg_o,
  output logic [VALUE_WIDTH-1:0]       targetCompId_o,
  output logic [NUM_HOST-1:0]          host_o,
  output logic [$clog2(DEPTH):0]       pending_o,
  output logic                         overflow_o,
  output logic                         bad_req_o,
  output logic                         timeout_o,
  output logic [7:0]                   drop_cnt_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(DONE_TIMEOUT);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [TW-1:0] TMO_LAST = TW'(DONE_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2
  } state_e;

  // Request storage, one slot per FIFO entry
  logic [3:0]             typeMem_q   [DEPTH];
  logic [NUM_HOST-1:0]    hostMem_q   [DEPTH];
  logic [VALUE_WIDTH-1:0] compidMem_q [DEPTH];

  logic [AW-1:0] wrPtr_q, rdPtr_q;
  logic [CW-1:0] count_q, count_d;

  state_e                 state_q, state_d;
  logic [3:0]             msgType_q, msgType_d;
  logic [VALUE_WIDTH-1:0] compid_q, compid_d;
  logic [NUM_HOST-1:0]    host_q, host_d;
  logic                   initiate_q, initiate_d;
  logic                   timeout_q, timeout_d;
  logic [TW-1:0]          tmoCnt_q, tmoCnt_d;

  logic       overflow_q, badReq_q;
  logic [7:0] dropCnt_q;

  logic legalType, fifoFull, fifoEmpty, pop, push, dropBad, dropOvf;

  assign legalType = (req_type_i >= 4'd1) && (req_type_i <= 4'd4);
  assign fifoFull  = (count_q == DEPTH_C);
  assign fifoEmpty = (count_q == '0);
  // The head leaves the queue only when the scheduler is idle and the creator can accept it
  assign pop       = (state_q == IDLE) && !fifoEmpty && !creator_busy_i;
  // A full queue still accepts a request when the head is leaving in the same cycle
  assign push      = req_valid_i && legalType && (!fifoFull || pop);
  assign dropBad   = req_valid_i && !legalType;
  assign dropOvf   = req_valid_i && legalType && !push;

  // Occupancy follows the push/pop combination of this cycle
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Write accepted requests into the slot at the write pointer; contents need no reset
  always_ff @(posedge clk) begin
    if (push) begin
      typeMem_q[wrPtr_q]   <= req_type_i;
      hostMem_q[wrPtr_q]   <= req_host_i;
      compidMem_q[wrPtr_q] <= req_compid_i;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (push) wrPtr_q <= wrPtr_q + AW'(1);
      if (pop)  rdPtr_q <= rdPtr_q + AW'(1);
      count_q <= count_d;
    end
  end

  // Drop flags pulse the cycle after the offending request; an illegal type wins over overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      badReq_q   <= 1'b0;
      overflow_q <= 1'b0;
      dropCnt_q  <= '0;
    end else begin
      badReq_q   <= dropBad;
      overflow_q <= dropOvf;
      if ((dropBad || dropOvf) && (dropCnt_q != 8'hFF)) dropCnt_q <= dropCnt_q + 8'd1;
    end
  end

  // Issue sequencing: load the head, pulse the start, then hold until done or timeout
  always_comb begin
    state_d    = state_q;
    msgType_d  = msgType_q;
    compid_d   = compid_q;
    host_d     = host_q;
    initiate_d = 1'b0;
    timeout_d  = 1'b0;
    tmoCnt_d   = tmoCnt_q;
    case (state_q)
      IDLE: begin
        if (pop) begin
          msgType_d = typeMem_q[rdPtr_q];
          compid_d  = compidMem_q[rdPtr_q];
          host_d    = hostMem_q[rdPtr_q];
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        initiate_d = 1'b1;
        tmoCnt_d   = '0;
        state_d    = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (creator_done_i) begin
          msgType_d = '0;
          compid_d  = '0;
          host_d    = '0;
          state_d   = IDLE;
        end else if (tmoCnt_q == TMO_LAST) begin
          timeout_d = 1'b1;
          msgType_d = '0;
          compid_d  = '0;
          host_d    = '0;
          state_d   = IDLE;
        end else begin
          tmoCnt_d = tmoCnt_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Issue state and registered creator-facing outputs; reset abandons any in-flight message
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      msgType_q  <= '0;
      compid_q   <= '0;
      host_q     <= '0;
      initiate_q <= 1'b0;
      timeout_q  <= 1'b0;
      tmoCnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      msgType_q  <= msgType_d;
      compid_q   <= compid_d;
      host_q     <= host_d;
      initiate_q <= initiate_d;
      timeout_q  <= timeout_d;
      tmoCnt_q   <= tmoCnt_d;
    end
  end

  assign create_message_o = msgType_q;
  assign initiate_msg_o   = initiate_q;
  assign targetCompId_o   = compid_q;
  assign host_o           = host_q;
  assign pending_o        = count_q;
  assign overflow_o       = overflow_q;
  assign bad_req_o        = badReq_q;
  assign timeout_o        = timeout_q;
  assign drop_cnt_o       = dropCnt_q;

endmodule

// File: tb/tb_msg_request_scheduler.sv
// Testbench for msg_request_scheduler: table-driven enqueue/drop vectors, hand-written
// multi-cycle sequences, and a scoreboard checking the order and fields of issued messages.
module tb_msg_request_scheduler;

  localparam int NUM_HOST     = 10;
  localparam int VALUE_WIDTH  = 256;
  localparam int DEPTH        = 8;
  localparam int DONE_TIMEOUT = 32;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   req_valid_i;
  logic [3:0]             req_type_i;
  logic [NUM_HOST-1:0]    req_host_i;
  logic [VALUE_WIDTH-1:0] req_compid_i;
  logic                   creator_busy_i;
  logic                   creator_done_i;
  logic [3:0]             create_message_o;
  logic                   initiate_msg_o;
  logic [VALUE_WIDTH-1:0] targetCompId_o;
  logic [NUM_HOST-1:0]    host_o;
  logic [$clog2(DEPTH):0] pending_o;
  logic                   overflow_o;
  logic                   bad_req_o;
  logic                   timeout_o;
  logic [7:0]             drop_cnt_o;

  typedef struct {
    logic [3:0]             typ;
    logic [NUM_HOST-1:0]    host;
    logic [VALUE_WIDTH-1:0] cid;
  } exp_t;

  typedef struct {
    logic [3:0]          typ;
    logic [NUM_HOST-1:0] host;
    bit                  acc;
    bit                  expBad;
    bit                  expOvf;
    int                  expPend;
    int                  expDrop;
  } vec_t;

  exp_t sbq[$];
  vec_t vecs[13];
  int   testsRun    = 0;
  int   testsFailed = 0;

  msg_request_scheduler #(
    .NUM_HOST(NUM_HOST), .VALUE_WIDTH(VALUE_WIDTH), .DEPTH(DEPTH), .DONE_TIMEOUT(DONE_TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_type_i(req_type_i), .req_host_i(req_host_i),
    .req_compid_i(req_compid_i), .creator_busy_i(creator_busy_i), .creator_done_i(creator_done_i),
    .create_message_o(create_message_o), .initiate_msg_o(initiate_msg_o),
    .targetCompId_o(targetCompId_o), .host_o(host_o), .pending_o(pending_o),
    .overflow_o(overflow_o), .bad_req_o(bad_req_o), .timeout_o(timeout_o),
    .drop_cnt_o(drop_cnt_o)
  );

  // Free-running clock
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [255:0] actual,
                             input logic [255:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] t, input logic [NUM_HOST-1:0] h,
                               input logic [VALUE_WIDTH-1:0] c, input bit acc);
    exp_t e;
    req_valid_i  = 1'b1;
    req_type_i   = t;
    req_host_i   = h;
    req_compid_i = c;
    if (acc) begin
      e.typ  = t;
      e.host = h;
      e.cid  = c;
      sbq.push_back(e);
    end
    step();
    req_valid_i  = 1'b0;
    req_type_i   = 4'd0;
  endtask

  task automatic pulseDone();
    creator_done_i = 1'b1;
    step();
    creator_done_i = 1'b0;
  endtask

  task automatic waitInitiate(input string name);
    bit seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      step();
      if (initiate_msg_o === 1'b1) seen = 1'b1;
    end
    testsRun++;
    if (!seen) begin
      testsFailed++;
      $display("[TB] FAIL %s: initiate_msg_o got no pulse within 40 cycles, expected a pulse", name);
    end
  endtask

  task automatic checkAllZero(input string name);
    checkOutput({name, "_type"}, create_message_o, 0);
    checkOutput({name, "_init"}, initiate_msg_o, 0);
    checkOutput({name, "_cid"}, targetCompId_o, 0);
    checkOutput({name, "_host"}, host_o, 0);
    checkOutput({name, "_pend"}, pending_o, 0);
    checkOutput({name, "_ovf"}, overflow_o, 0);
    checkOutput({name, "_bad"}, bad_req_o, 0);
    checkOutput({name, "_tmo"}, timeout_o, 0);
    checkOutput({name, "_drop"}, drop_cnt_o, 0);
  endtask

  // Scoreboard monitor: every start pulse must match the oldest expected request
  always begin : monitor
    exp_t e;
    @(posedge clk);
    #1;
    if (initiate_msg_o === 1'b1) begin
      if (sbq.size() == 0) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL sb_unexpected_issue: got issue of type %0h host %0d, expected none",
                 create_message_o, host_o);
      end else begin
        e = sbq.pop_front();
        checkOutput("sb_type", create_message_o, e.typ);
        checkOutput("sb_host", host_o, e.host);
        checkOutput("sb_cid", targetCompId_o, e.cid);
      end
    end
  end

  // Overall time guard so the bench always terminates
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion by 200000 time units, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cyc;
    bit seenT;

    vecs[0]  = '{4'd1,  10'd1,  1'b1, 1'b0, 1'b0, 1, 0};
    vecs[1]  = '{4'd4,  10'd2,  1'b1, 1'b0, 1'b0, 2, 0};
    vecs[2]  = '{4'd3,  10'd3,  1'b1, 1'b0, 1'b0, 3, 0};
    vecs[3]  = '{4'd7,  10'd4,  1'b0, 1'b1, 1'b0, 3, 1};
    vecs[4]  = '{4'd0,  10'd5,  1'b0, 1'b1, 1'b0, 3, 2};
    vecs[5]  = '{4'd2,  10'd6,  1'b1, 1'b0, 1'b0, 4, 2};
    vecs[6]  = '{4'd1,  10'd7,  1'b1, 1'b0, 1'b0, 5, 2};
    vecs[7]  = '{4'd2,  10'd8,  1'b1, 1'b0, 1'b0, 6, 2};
    vecs[8]  = '{4'd3,  10'd9,  1'b1, 1'b0, 1'b0, 7, 2};
    vecs[9]  = '{4'd4,  10'd10, 1'b1, 1'b0, 1'b0, 8, 2};
    vecs[10] = '{4'd1,  10'd11, 1'b0, 1'b0, 1'b1, 8, 3};
    vecs[11] = '{4'd2,  10'd12, 1'b0, 1'b0, 1'b1, 8, 4};
    vecs[12] = '{4'd15, 10'd13, 1'b0, 1'b1, 1'b0, 8, 5};

    rst            = 1'b1;
    req_valid_i    = 1'b0;
    req_type_i     = 4'd0;
    req_host_i     = '0;
    req_compid_i   = '0;
    creator_busy_i = 1'b0;
    creator_done_i = 1'b0;

    // Reset state
    repeat (2) step();
    checkAllZero("reset");
    rst = 1'b0;
    step();
    checkAllZero("post_reset");

    // Single heartbeat: latency and hold until done
    applyStimulus(4'd2, 10'd3, 256'hA5, 1'b1);
    checkOutput("t1_k_pend", pending_o, 1);
    checkOutput("t1_k_init", initiate_msg_o, 0);
    step();
    checkOutput("t1_k1_init", initiate_msg_o, 0);
    checkOutput("t1_k1_pend", pending_o, 0);
    step();
    checkOutput("t1_k2_init", initiate_msg_o, 1);
    checkOutput("t1_k2_type", create_message_o, 2);
    checkOutput("t1_k2_host", host_o, 3);
    step();
    checkOutput("t1_k3_init", initiate_msg_o, 0);
    repeat (4) step();
    checkOutput("t1_hold_type", create_message_o, 2);
    checkOutput("t1_hold_host", host_o, 3);
    checkOutput("t1_hold_cid", targetCompId_o, 256'hA5);
    pulseDone();
    checkOutput("t1_done_type", create_message_o, 0);
    checkOutput("t1_done_host", host_o, 0);
    checkOutput("t1_done_cid", targetCompId_o, 0);

    // Three requests while busy, then drain in order
    creator_busy_i = 1'b1;
    applyStimulus(4'd1, 10'd21, 256'h1111, 1'b1);
    applyStimulus(4'd4, 10'd22, 256'h2222, 1'b1);
    applyStimulus(4'd3, 10'd23, 256'h3333, 1'b1);
    checkOutput("t2_pend3", pending_o, 3);
    creator_busy_i = 1'b0;
    for (int k = 2; k >= 0; k--) begin
      waitInitiate("t2_issue");
      checkOutput("t2_pend", pending_o, k);
      pulseDone();
    end

    // Enqueue and drop table with the creator held busy
    creator_busy_i = 1'b1;
    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].typ, vecs[i].host, {16'hBEEF, 240'(i)}, vecs[i].acc);
      checkOutput($sformatf("tab%0d_pend", i), pending_o, vecs[i].expPend);
      checkOutput($sformatf("tab%0d_bad", i), bad_req_o, vecs[i].expBad);
      checkOutput($sformatf("tab%0d_ovf", i), overflow_o, vecs[i].expOvf);
      checkOutput($sformatf("tab%0d_drop", i), drop_cnt_o, vecs[i].expDrop);
    end
    step();
    checkOutput("tab_idle_bad", bad_req_o, 0);
    checkOutput("tab_idle_ovf", overflow_o, 0);

    // Push at full with a simultaneous pop is accepted
    creator_busy_i = 1'b0;
    applyStimulus(4'd2, 10'd20, 256'h2020, 1'b1);
    checkOutput("full_pop_pend", pending_o, 8);
    checkOutput("full_pop_ovf", overflow_o, 0);
    checkOutput("full_pop_drop", drop_cnt_o, 5);

    // Withheld done: timeout after DONE_TIMEOUT cycles, then next request issues
    waitInitiate("t5_issue");
    cyc   = 0;
    seenT = 1'b0;
    while (!seenT && cyc < DONE_TIMEOUT + 8) begin
      step();
      cyc++;
      if (timeout_o === 1'b1) seenT = 1'b1;
    end
    checkOutput("t5_tmo_seen", seenT, 1);
    checkOutput("t5_tmo_cycles", cyc, DONE_TIMEOUT);
    checkOutput("t5_tmo_type", create_message_o, 0);
    checkOutput("t5_tmo_host", host_o, 0);
    for (int k = 7; k >= 4; k--) begin
      waitInitiate("t5_next");
      checkOutput("t5_pend", pending_o, k);
      pulseDone();
    end
    waitInitiate("t6_issue");
    checkOutput("t6_pend3", pending_o, 3);

    // Reset during WAIT_DONE drops everything; a late done is ignored
    step();
    rst = 1'b1;
    sbq.delete();
    step();
    rst = 1'b0;
    checkAllZero("t6_reset");
    pulseDone();
    repeat (5) step();
    checkOutput("t6_late_pend", pending_o, 0);
    checkOutput("t6_late_type", create_message_o, 0);
    checkOutput("t6_late_tmo", timeout_o, 0);

    checkOutput("sb_drained", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
